fabric_frac_lut_ff_cfg: RTL and testbench

- Parametrised successor of the physical fle fabric tile: a K-input fracturable LUT, two flip-flops with scan and register-chain paths, and per-output comb/registered muxes.
- Adds what the fixed tile lacks:
  - K as a parameter;
  - an integrated configuration shift chain with a bit counter and load-done flag;
  - per-FF configurable init values;
  - an optional clock enable;
  - an FF0→FF1 cascade.
- Sits inside a clb as one fle slot; the ccff chain threads through slots.

---
 rtl/fabric_frac_lut_ff_cfg_pkg.sv | 24 ++
 rtl/fabric_frac_lut_ff_cfg_if.sv | 12 +
 rtl/fabric_ccff_chain.sv | 38 +++
 rtl/fabric_frac_lut_ff_cfg.sv | 98 +++++++++
 tb/tb_fabric_frac_lut_ff_cfg.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fabric_frac_lut_ff_cfg_pkg.sv
// Shared constants for the fracturable LUT/FF tile: configuration chain length
// and the offsets of the control fields that sit above the LUT table.
package fabric_cfg_pkg;

  // Control field offsets, relative to the end of the 2**K-bit LUT table.
  localparam int OFS_FRAC     = 0;
  localparam int OFS_FF0_DSEL = 1;
  localparam int OFS_OUT0_SEL = 2;
  localparam int OFS_OUT1_SEL = 3;
  localparam int OFS_FF1_DSEL = 4;
  localparam int OFS_CE_USED  = 5;
  localparam int OFS_INIT0    = 6;
  localparam int OFS_INIT1    = 7;

  function automatic int cfg_bits(input int k);
    return (1 << k) + 8;
  endfunction

  // Absolute bit position of a control field inside cfg for a given K.
  function automatic int cfg_ofs(input int k, input int ofs);
    return (1 << k) + ofs;
  endfunction

endpackage

// File: rtl/fabric_frac_lut_ff_cfg_if.sv
// Configuration-chain port bundle of one fle slot (ccff chain threads slot to slot).
interface fabric_frac_lut_ff_cfg_if;
  // ccff_en qualifies ccff_head on every fabric_clk edge; there is no
  // backpressure, the loader owns the pace and watches cfg_done.
  logic ccff_en;
  logic ccff_head;
  logic ccff_tail;
  logic cfg_done;

  modport master (output ccff_en, ccff_head, input ccff_tail, cfg_done);
  modport slave  (input ccff_en, ccff_head, output ccff_tail, cfg_done);
endinterface

// File: rtl/fabric_ccff_chain.sv
// Configuration shift register with enable edge detect, saturating bit counter
// and load-done flag.
module fabric_ccff_chain #(
  parameter int N     = 24,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         head,
  output logic [N-1:0] cfg,
  output logic         en_q,
  output logic         done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg   <= '0;
      count <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= en;
      if (en) begin
        cfg <= {cfg[N-2:0], head};
        // A fresh rise of en restarts the count on this very shift.
        if (!en_q)
          count <= CNT_W'(1);
        else if (count != CNT_W'(N))
          count <= count + 1'b1;
      end
    end
  end

  assign done = (count == CNT_W'(N));

endmodule

// File: rtl/fabric_frac_lut_ff_cfg.sv
// One fle slot: K-input fracturable LUT, two FFs with scan/register-chain and
// cascade paths, comb/registered output muxes, and its own ccff config chain.
module fabric_frac_lut_ff_cfg
  import fabric_cfg_pkg::*;
#(
  parameter int K        = 4,
  parameter int CFG_BITS = cfg_bits(K),
  parameter int CNT_W    = $clog2((1 << K) + 9)
) (
  input  logic                     fabric_clk,
  input  logic                     fabric_rst_n,
  input  logic                     Test_en,
  fabric_frac_lut_ff_cfg_if.slave  ccff,
  input  logic [K-1:0]             fabric_in,
  input  logic                     fabric_ce,
  input  logic                     fabric_reg_in,
  input  logic                     fabric_sc_in,
  output logic [1:0]               fabric_out,
  output logic                     fabric_reg_out,
  output logic                     fabric_sc_out
);

  localparam int T = 1 << K;

  logic [CFG_BITS-1:0] cfg;
  logic                en_q;

  fabric_ccff_chain #(.N(CFG_BITS), .CNT_W(CNT_W)) u_chain (
    .clk   (fabric_clk),
    .rst_n (fabric_rst_n),
    .en    (ccff.ccff_en),
    .head  (ccff.ccff_head),
    .cfg   (cfg),
    .en_q  (en_q),
    .done  (ccff.cfg_done)
  );

  assign ccff.ccff_tail = cfg[CFG_BITS-1];

  logic [T-1:0] lut_tab;
  logic         frac_mode, ff0_dsel, out0_sel, out1_sel, ff1_dsel, ce_used, init0, init1;

  assign lut_tab   = cfg[T-1:0];
  assign frac_mode = cfg[cfg_ofs(K, OFS_FRAC)];
  assign ff0_dsel  = cfg[cfg_ofs(K, OFS_FF0_DSEL)];
  assign out0_sel  = cfg[cfg_ofs(K, OFS_OUT0_SEL)];
  assign out1_sel  = cfg[cfg_ofs(K, OFS_OUT1_SEL)];
  assign ff1_dsel  = cfg[cfg_ofs(K, OFS_FF1_DSEL)];
  assign ce_used   = cfg[cfg_ofs(K, OFS_CE_USED)];
  assign init0     = cfg[cfg_ofs(K, OFS_INIT0)];
  assign init1     = cfg[cfg_ofs(K, OFS_INIT1)];

  logic [K-2:0] frac_idx;
  logic         lut_out0, lut_out1;

  assign frac_idx = fabric_in[K-2:0];

  // Fractured mode splits the table: lower half feeds out0, upper half out1.
  always_comb begin
    lut_out0 = lut_tab[fabric_in];
    lut_out1 = lut_out0;
    if (frac_mode) begin
      lut_out0 = lut_tab[{1'b0, frac_idx}];
      lut_out1 = lut_tab[{1'b1, frac_idx}];
    end
  end

  logic ff0_q, ff1_q, d0, d1;

  assign d0 = ff0_dsel ? fabric_reg_in : lut_out0;
  assign d1 = ff1_dsel ? ff0_q : lut_out1;

  always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
    if (!fabric_rst_n) begin
      ff0_q <= 1'b0;
      ff1_q <= 1'b0;
    end else if (ccff.ccff_en) begin
      ff0_q <= ff0_q;
      ff1_q <= ff1_q;
    end else if (en_q) begin
      // Load just finished: cfg now holds the complete word, apply init values.
      ff0_q <= init0;
      ff1_q <= init1;
    end else if (Test_en) begin
      ff0_q <= fabric_sc_in;
      ff1_q <= ff0_q;
    end else if (!(ce_used && !fabric_ce)) begin
      ff0_q <= d0;
      ff1_q <= d1;
    end
  end

  assign fabric_out[0]  = out0_sel ? ff0_q : lut_out0;
  assign fabric_out[1]  = out1_sel ? ff1_q : lut_out1;
  assign fabric_reg_out = ff1_q;
  assign fabric_sc_out  = ff1_q;

endmodule

// File: tb/tb_fabric_frac_lut_ff_cfg.sv
// Randomized scoreboard bench for fabric_frac_lut_ff_cfg (K=4) against a
// bit-history reference model of the configuration chain and the FF rules.
module tb_fabric_frac_lut_ff_cfg;

  localparam int K  = 4;
  localparam int T  = 16;
  localparam int NB = 24;

  logic         fabric_clk = 1'b0;
  logic         fabric_rst_n;
  logic         Test_en;
  logic [K-1:0] fabric_in;
  logic         fabric_ce;
  logic         fabric_reg_in;
  logic         fabric_sc_in;
  logic [1:0]   fabric_out;
  logic         fabric_reg_out;
  logic         fabric_sc_out;

  fabric_frac_lut_ff_cfg_if ccff ();

  fabric_frac_lut_ff_cfg #(.K(K)) dut (
    .fabric_clk     (fabric_clk),
    .fabric_rst_n   (fabric_rst_n),
    .Test_en        (Test_en),
    .ccff           (ccff),
    .fabric_in      (fabric_in),
    .fabric_ce      (fabric_ce),
    .fabric_reg_in  (fabric_reg_in),
    .fabric_sc_in   (fabric_sc_in),
    .fabric_out     (fabric_out),
    .fabric_reg_out (fabric_reg_out),
    .fabric_sc_out  (fabric_sc_out)
  );

  // ---------------- clock ----------------
  always #5 fabric_clk = ~fabric_clk;

  // ---------------- reference model ----------------
  // hist[0] is the most recently shifted bit, so cfg bit i == hist[i].
  bit hist[$];
  int m_shifted;
  bit m_en_prev;
  bit m_ff0, m_ff1;

  function automatic bit cbit(input int i);
    if (i < hist.size()) return hist[i];
    return 1'b0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_shifted = 0;
    m_en_prev = 1'b0;
    m_ff0     = 1'b0;
    m_ff1     = 1'b0;
  endfunction

  function automatic void lut_eval(output bit l0, output bit l1);
    int idx;
    if (cbit(T)) begin
      idx = int'(fabric_in) % (T / 2);
      l0  = cbit(idx);
      l1  = cbit(T / 2 + idx);
    end else begin
      l0 = cbit(int'(fabric_in));
      l1 = l0;
    end
  endfunction

  function automatic logic [5:0] model_out();
    bit l0, l1, o0, o1, done;
    lut_eval(l0, l1);
    o0   = cbit(T + 2) ? m_ff0 : l0;
    o1   = cbit(T + 3) ? m_ff1 : l1;
    done = (m_shifted >= NB);
    return {done, cbit(NB - 1), m_ff1, m_ff1, o1, o0};
  endfunction

  function automatic void model_edge();
    bit l0, l1, n0, n1;
    if (!fabric_rst_n) begin
      model_reset();
      return;
    end
    lut_eval(l0, l1);
    n0 = m_ff0;
    n1 = m_ff1;
    if (ccff.ccff_en) begin
      m_shifted = m_en_prev ? m_shifted + 1 : 1;
      hist.push_front(ccff.ccff_head);
      if (hist.size() > NB) void'(hist.pop_back());
    end else if (m_en_prev) begin
      n0 = cbit(T + 6);
      n1 = cbit(T + 7);
    end else if (Test_en) begin
      n0 = fabric_sc_in;
      n1 = m_ff0;
    end else if (!(cbit(T + 5) && !fabric_ce)) begin
      n0 = cbit(T + 1) ? fabric_reg_in : l0;
      n1 = cbit(T + 4) ? m_ff0 : l1;
    end
    m_ff0     = n0;
    m_ff1     = n1;
    m_en_prev = ccff.ccff_en;
  endfunction

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  string      name_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  always @(negedge fabric_clk) begin
    logic [5:0] exp_v, got_v;
    string      nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {ccff.cfg_done, ccff.ccff_tail, fabric_reg_out, fabric_sc_out, fabric_out};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL %s @%0t: {done,tail,reg,sc,out} got %b expected %b", nm, $time, got_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are set by the caller; the expectation for the current cycle is
  // queued, then the model advances across the next rising edge.
  task automatic step(input string name);
    if (!fabric_rst_n) model_reset();
    exp_q.push_back(model_out());
    name_q.push_back(name);
    @(posedge fabric_clk);
    model_edge();
    #2;
  endtask

  function automatic logic [23:0] mkcfg(input logic [15:0] tbl, input logic frac, ff0d,
                                        o0, o1, ff1d, ceu, i0, i1);
    return {i1, i0, ceu, ff1d, o1, o0, ff0d, frac, tbl};
  endfunction

  // First-shifted bit lands at the MSB, so send the word MSB first.
  task automatic load(input logic [23:0] word, input string name);
    for (int i = NB - 1; i >= 0; i--) begin
      ccff.ccff_en   = 1'b1;
      ccff.ccff_head = word[i];
      step(name);
    end
    ccff.ccff_en = 1'b0;
    step({name, "_fall"});
  endtask

  task automatic shift_random(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      ccff.ccff_en   = 1'b1;
      ccff.ccff_head = 1'($urandom_range(0, 1));
      step(name);
    end
    ccff.ccff_en = 1'b0;
  endtask

  task automatic random_user(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      fabric_in     = K'($urandom_range(0, T - 1));
      fabric_ce     = 1'($urandom_range(0, 1));
      fabric_reg_in = 1'($urandom_range(0, 1));
      fabric_sc_in  = 1'($urandom_range(0, 1));
      Test_en       = ($urandom_range(0, 5) == 0);
      step(name);
    end
    Test_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    fabric_rst_n   = 1'b0;
    Test_en        = 1'b0;
    fabric_in      = '0;
    fabric_ce      = 1'b0;
    fabric_reg_in  = 1'b0;
    fabric_sc_in   = 1'b0;
    ccff.ccff_en   = 1'b0;
    ccff.ccff_head = 1'b0;
    model_reset();
    @(posedge fabric_clk);
    #2;
    step("reset");
    step("reset");
    fabric_rst_n = 1'b1;
    fabric_in    = 4'hF;
    step("post_reset_F");
    step("post_reset_F");

    // Full load: AND4 table, everything combinational.
    load(mkcfg(16'h8000, 0, 0, 0, 0, 0, 0, 0, 0), "load_and4");
    fabric_in = 4'hF; step("and4_F");
    fabric_in = 4'hE; step("and4_E");

    // Fractured: out0 reads bits 0..7, out1 reads bits 8..15.
    load(mkcfg(16'h8001, 1, 0, 0, 0, 0, 0, 0, 0), "load_frac");
    foreach (fabric_in[i]) ;
    for (int v = 0; v < T; v++) begin
      fabric_in = K'(v);
      step("frac_sweep");
    end

    // Init values and FF0->FF1 cascade through registered outputs.
    load(mkcfg(16'h0000, 0, 0, 1, 1, 1, 0, 1, 0), "load_init");
    fabric_in = 4'h0;
    step("cascade_edge");
    step("cascade_after");
    step("cascade_settle");

    // Clock enable hold, then scan shift that ignores the enable.
    load(mkcfg(16'hA5C3, 0, 0, 1, 1, 0, 1, 1, 1), "load_ce");
    fabric_ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fabric_in = K'($urandom_range(0, T - 1));
      step("ce_hold");
    end
    Test_en = 1'b1;
    fabric_sc_in = 1'b1; step("scan1");
    fabric_sc_in = 1'b0; step("scan0");
    step("scan_out");
    Test_en = 1'b0;
    fabric_ce = 1'b1;
    step("ce_release");

    // Interrupted load, reload, and over-shift.
    shift_random(10, "short_load");
    step("short_fall");
    step("short_idle");
    shift_random(NB, "reload");
    step("reload_fall");
    shift_random(30, "overshift");
    step("overshift_fall");
    random_user(8, "after_overshift");

    // Reset in the middle of a shift discards the partial word.
    shift_random(5, "pre_reset_shift");
    fabric_rst_n = 1'b0;
    step("mid_reset");
    fabric_rst_n = 1'b1;
    step("after_mid_reset");
    step("after_mid_reset");

    // Randomized configurations and user traffic, scan sometimes held high during loads.
    for (int r = 0; r < 8; r++) begin
      Test_en = 1'($urandom_range(0, 1));
      load(24'($urandom()), "rand_load");
      Test_en = 1'b0;
      random_user(20, "rand_user");
      if (r == 4) begin
        fabric_rst_n = 1'b0;
        step("rand_reset");
        fabric_rst_n = 1'b1;
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge fabric_clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
